lap_ram_arbiter: RTL and testbench
==================================

LAP_RAM_ARBITER -- requirements
Module: lap_ram_arbiter

Interface
REQ-001 Parameters SHALL be: DW, 24, lap time width (BCD digits); AW, 4, RAM address width; DEPTH, 16, entries (2**AW); RD_LAT, 1, RAM read latency in clocks.
REQ-002 clk  in  1  single clock; all state changes on the rising edge.
REQ-003 rst_n  in  1  asynchronous, active-low reset.
REQ-004 rec_req  in  1  one-cycle pulse: store the current lap time.
REQ-005 rec_data  in  DW  watch count, sampled in the cycle rec_req is accepted.
REQ-006 rd_req  in  1  one-cycle pulse: recall the next stored lap.
REQ-007 clr_req  in  1  one-cycle pulse: discard all stored laps.
REQ-008 ram_addr  out  AW  registered RAM address.
REQ-009 ram_wren  out  1  registered RAM write enable.
REQ-010 ram_wdata  out  DW  registered RAM write data.
REQ-011 ram_rdata  in  DW  RAM read data, valid RD_LAT clocks after ram_addr.
REQ-012 rec_ack  out  1  one-cycle pulse: write committed.
REQ-013 rec_drop  out  1  one-cycle pulse: record refused because the store is full.
REQ-014 rd_data  out  DW  last recalled lap, held until the next recall.
REQ-015 rd_valid  out  1  one-cycle pulse: rd_data updated.
REQ-016 lap_count  out  AW+1  number of stored laps, 0..DEPTH.
REQ-017 full / empty / busy  out  1 each  lap_count==DEPTH / lap_count==0 / FSM not in IDLE.

Function
REQ-018 The FSM SHALL have states IDLE, WRITE, RD_ADDR, RD_WAIT and RD_CAP.
REQ-019 In IDLE, a request source SHALL be a pending flag OR a same-cycle pulse; record SHALL win over recall.
REQ-020 An accepted record in IDLE with !full SHALL set ram_addr=wr_ptr, ram_wdata=rec_data and ram_wren=1 for exactly one cycle (WRITE), then return to IDLE.
REQ-021 On leaving WRITE: wr_ptr+1 mod DEPTH, lap_count+1, rec_ack pulse, read cursor set to the newly written entry.
REQ-022 A record request while full SHALL pulse rec_drop on the next cycle; no RAM write occurs and no state changes.
REQ-023 An accepted recall in IDLE with !empty: RD_ADDR drives ram_addr=cursor; RD_WAIT lasts RD_LAT cycles; RD_CAP registers ram_rdata into rd_data and pulses rd_valid; then IDLE.
REQ-024 Recall latency SHALL be rd_req at cycle T -> rd_valid at cycle T+RD_LAT+2 when idle and uncontended.
REQ-025 After each recall the cursor SHALL step to the next older entry (mod DEPTH); after the oldest entry (wr_ptr-lap_count) it SHALL wrap to the newest (wr_ptr-1).
REQ-026 A recall request while empty SHALL be discarded: no RAM access, no rd_valid.
REQ-027 A request arriving while busy SHALL set that source's one-deep pending flag; a further pulse while the flag is set SHALL be lost; the flag clears when the request is served.
REQ-028 clr_req SHALL win in any state: the next cycle is IDLE with ram_wren=0; wr_ptr, lap_count, cursor and pending flags are zeroed; a read in progress is aborted without rd_valid; rd_data is retained; RAM contents are not erased.
REQ-029 If clr_req coincides with rec_req or rd_req, clear SHALL take effect and the coincident request SHALL be discarded.
REQ-030 ram_wren SHALL never be asserted outside WRITE; ram_addr SHALL be stable for the whole of RD_ADDR and RD_WAIT.

Reset
REQ-031 While rst_n=0: state=IDLE; ram_addr=0, ram_wren=0, ram_wdata=0, rd_data=0, rec_ack=0, rec_drop=0, rd_valid=0, lap_count=0, empty=1, full=0, busy=0; pointers and pending flags are 0.
REQ-032 Reset assertion mid-write or mid-read SHALL drop ram_wren immediately (asynchronously); no partial state survives.

Structure
REQ-033 FSM state encodings, DW and AW defaults SHALL live in a shared watch package, also used by the key controller and display mux.
REQ-034 One sub-module, lap_ptr_ring, SHALL hold wr_ptr, lap_count and cursor with the modulo wrap logic; the FSM and RAM port registers remain in lap_ram_arbiter.

Verification
REQ-035 Reset, then rec_req with rec_data=0x000123 -> ram_wren=1 at addr 0 for one cycle, rec_ack, lap_count=1, empty=0.
REQ-036 Store 16 laps (0x000001..0x000010), then a 17th rec_req -> full=1, rec_drop pulse, no ram_wren.
REQ-037 3 laps A,B,C stored, then 4 rd_req pulses -> rd_data C,B,A,C; each rd_valid arrives exactly 3 cycles after its rd_req (RD_LAT=1).
REQ-038 rec_req and rd_req in the same cycle with 1 lap stored -> write first, then the recall returns the new lap; no request is lost.
REQ-039 clr_req during RD_WAIT -> no rd_valid, lap_count=0, empty=1; a following rd_req is ignored.
REQ-040 rst_n driven low during WRITE -> ram_wren falls without waiting for a clock edge; all outputs match REQ-031.

Source files
------------

// File: rtl/lap_ram_arbiter_pkg.sv
// Shared stopwatch definitions: lap-time width, lap RAM geometry, arbiter FSM encodings.
// Latency: n/a (constants only).
// Backpressure: n/a.
package lap_ram_arbiter_pkg;

    // Lap time is six BCD digits (HH:MM:SS or MM:SS:cc depending on mode)
    localparam int LAP_DW    = 24;
    localparam int LAP_AW    = 4;
    localparam int LAP_DEPTH = 16;

    // Arbiter FSM encodings, kept as plain constants so older blocks can share them
    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_WRITE   = 3'd1;
    localparam logic [2:0] ST_RD_ADDR = 3'd2;
    localparam logic [2:0] ST_RD_WAIT = 3'd3;
    localparam logic [2:0] ST_RD_CAP  = 3'd4;

endpackage

// File: rtl/lap_ptr_ring.sv
// Lap store bookkeeping: write pointer, stored-lap count and newest-to-oldest recall cursor.
// Latency: updates on the clock edge following a commit/step/clear strobe.
// Backpressure: none; the owner only commits when not full and steps when not empty.
module lap_ptr_ring
    import lap_ram_arbiter_pkg::*;
#(
    parameter int AW    = LAP_AW,
    parameter int DEPTH = LAP_DEPTH
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          wr_commit,
    input  logic          rd_step,
    output logic [AW-1:0] wr_ptr,
    output logic [AW-1:0] cursor,
    output logic [AW:0]   lap_count,
    output logic          full,
    output logic          empty
);

    localparam logic [AW:0] CNT_MAX = (AW+1)'(DEPTH);

    logic [AW-1:0] oldest;
    logic [AW-1:0] newest;

    // With DEPTH == 2**AW a full store truncates the count to 0, so oldest lands on wr_ptr
    assign oldest = wr_ptr - lap_count[AW-1:0];
    assign newest = wr_ptr - AW'(1);
    assign full   = (lap_count == CNT_MAX);
    assign empty  = (lap_count == '0);

    // Pointer state: clear dominates, a commit points the cursor at the fresh entry, a recall walks backwards
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            cursor    <= '0;
            lap_count <= '0;
        end else if (clr) begin
            wr_ptr    <= '0;
            cursor    <= '0;
            lap_count <= '0;
        end else if (wr_commit) begin
            wr_ptr <= wr_ptr + AW'(1);
            cursor <= wr_ptr;
            if (lap_count != CNT_MAX) begin
                lap_count <= lap_count + (AW+1)'(1);
            end
        end else if (rd_step) begin
            cursor <= (cursor == oldest) ? newest : (cursor - AW'(1));
        end
    end

endmodule

// File: rtl/lap_ram_arbiter.sv
// Lap RAM arbiter: serialises record / recall / clear requests onto a single-port lap RAM.
// Latency: record ack 2 clocks after rec_req; recall rd_valid RD_LAT+2 clocks after rd_req (idle, uncontended).
// Backpressure: none; requests arriving while busy park in a one-deep pending flag, extra pulses are lost.
module lap_ram_arbiter
    import lap_ram_arbiter_pkg::*;
#(
    parameter int DW     = LAP_DW,
    parameter int AW     = LAP_AW,
    parameter int DEPTH  = LAP_DEPTH,
    parameter int RD_LAT = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          rec_req,
    input  logic [DW-1:0] rec_data,
    input  logic          rd_req,
    input  logic          clr_req,
    output logic [AW-1:0] ram_addr,
    output logic          ram_wren,
    output logic [DW-1:0] ram_wdata,
    input  logic [DW-1:0] ram_rdata,
    output logic          rec_ack,
    output logic          rec_drop,
    output logic [DW-1:0] rd_data,
    output logic          rd_valid,
    output logic [AW:0]   lap_count,
    output logic          full,
    output logic          empty,
    output logic          busy
);

    localparam logic [7:0] WAIT_INIT = 8'(RD_LAT - 1);

    logic [2:0]    state;
    logic [2:0]    state_nxt;
    logic [7:0]    wait_cnt;
    logic          rec_pend;
    logic          rd_pend;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] cursor;

    logic in_idle;
    logic rec_src;
    logic rd_src;
    logic take_rec;
    logic take_rd;
    logic do_write;
    logic do_drop;
    logic do_read;
    logic wr_commit;
    logic rd_step;

    lap_ptr_ring #(
        .AW    (AW),
        .DEPTH (DEPTH)
    ) u_ring (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (clr_req),
        .wr_commit (wr_commit),
        .rd_step   (rd_step),
        .wr_ptr    (wr_ptr),
        .cursor    (cursor),
        .lap_count (lap_count),
        .full      (full),
        .empty     (empty)
    );

    assign busy = (state != ST_IDLE);

    // Request decode: record beats recall, clear suppresses both in the same cycle
    always_comb begin
        in_idle   = (state == ST_IDLE);
        rec_src   = rec_req | rec_pend;
        rd_src    = rd_req | rd_pend;
        take_rec  = in_idle & rec_src & ~clr_req;
        take_rd   = in_idle & ~rec_src & rd_src & ~clr_req;
        do_write  = take_rec & ~full;
        do_drop   = take_rec & full;
        do_read   = take_rd & ~empty;
        wr_commit = (state == ST_WRITE) & ~clr_req;
        rd_step   = (state == ST_RD_WAIT) & (wait_cnt == '0) & ~clr_req;
    end

    // Next-state selection
    always_comb begin
        state_nxt = ST_IDLE;
        if (!clr_req) begin
            case (state)
                ST_IDLE: begin
                    if (do_write) begin
                        state_nxt = ST_WRITE;
                    end else if (do_read) begin
                        state_nxt = ST_RD_ADDR;
                    end
                end
                ST_WRITE:   state_nxt = ST_IDLE;
                ST_RD_ADDR: state_nxt = ST_RD_WAIT;
                ST_RD_WAIT: state_nxt = (wait_cnt == '0) ? ST_RD_CAP : ST_RD_WAIT;
                ST_RD_CAP:  state_nxt = ST_IDLE;
                default:    state_nxt = ST_IDLE;
            endcase
        end
    end

    // FSM state, read-wait counter and per-source pending flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            wait_cnt <= '0;
            rec_pend <= 1'b0;
            rd_pend  <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == ST_RD_ADDR) begin
                wait_cnt <= WAIT_INIT;
            end else if ((state == ST_RD_WAIT) && (wait_cnt != '0)) begin
                wait_cnt <= wait_cnt - 8'd1;
            end
            if (clr_req) begin
                rec_pend <= 1'b0;
                rd_pend  <= 1'b0;
            end else begin
                // A served source clears; an unserved pulse parks (merging with a flag already set)
                rec_pend <= take_rec ? 1'b0 : (rec_pend | rec_req);
                rd_pend  <= take_rd  ? 1'b0 : (rd_pend | rd_req);
            end
        end
    end

    // RAM port and result registers; ram_addr only moves when a new access is launched
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ram_addr  <= '0;
            ram_wren  <= 1'b0;
            ram_wdata <= '0;
            rd_data   <= '0;
            rec_ack   <= 1'b0;
            rec_drop  <= 1'b0;
            rd_valid  <= 1'b0;
        end else begin
            ram_wren <= do_write;
            rec_ack  <= wr_commit;
            rec_drop <= do_drop;
            rd_valid <= rd_step;
            if (do_write) begin
                ram_addr  <= wr_ptr;
                ram_wdata <= rec_data;
            end else if (do_read) begin
                ram_addr <= cursor;
            end
            if (rd_step) begin
                rd_data <= ram_rdata;
            end
        end
    end

endmodule

// File: tb/tb_lap_ram_arbiter.sv
// Directed bench for lap_ram_arbiter with a one-clock-latency behavioural lap RAM.
// Latency: n/a.
// Backpressure: n/a.
module tb_lap_ram_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rec_req;
    logic [23:0] rec_data;
    logic        rd_req;
    logic        clr_req;
    logic [3:0]  ram_addr;
    logic        ram_wren;
    logic [23:0] ram_wdata;
    logic [23:0] ram_rdata;
    logic        rec_ack;
    logic        rec_drop;
    logic [23:0] rd_data;
    logic        rd_valid;
    logic [4:0]  lap_count;
    logic        full;
    logic        empty;
    logic        busy;

    int checks = 0;
    int errors = 0;

    logic [23:0] mem [16];

    lap_ram_arbiter #(
        .DW     (24),
        .AW     (4),
        .DEPTH  (16),
        .RD_LAT (1)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rec_req   (rec_req),
        .rec_data  (rec_data),
        .rd_req    (rd_req),
        .clr_req   (clr_req),
        .ram_addr  (ram_addr),
        .ram_wren  (ram_wren),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata),
        .rec_ack   (rec_ack),
        .rec_drop  (rec_drop),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid),
        .lap_count (lap_count),
        .full      (full),
        .empty     (empty),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Synchronous lap RAM, read data one clock after the address
    always @(posedge clk) begin
        if (ram_wren) mem[ram_addr] <= ram_wdata;
        ram_rdata <= mem[ram_addr];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_addr"},  32'(ram_addr),  32'd0);
        check({tag, "_wren"},  32'(ram_wren),  32'd0);
        check({tag, "_wdata"}, 32'(ram_wdata), 32'd0);
        check({tag, "_rdata"}, 32'(rd_data),   32'd0);
        check({tag, "_ack"},   32'(rec_ack),   32'd0);
        check({tag, "_drop"},  32'(rec_drop),  32'd0);
        check({tag, "_vld"},   32'(rd_valid),  32'd0);
        check({tag, "_cnt"},   32'(lap_count), 32'd0);
        check({tag, "_empty"}, 32'(empty),     32'd1);
        check({tag, "_full"},  32'(full),      32'd0);
        check({tag, "_busy"},  32'(busy),      32'd0);
    endtask

    // Record one lap and return in the rec_ack cycle
    task automatic do_rec(input logic [23:0] d);
        rec_req  = 1'b1;
        rec_data = d;
        tick();
        rec_req = 1'b0;
        tick();
    endtask

    task automatic do_clr();
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
    endtask

    // Issue rd_req, measure cycles to rd_valid, check data, then step past the RD_CAP cycle
    task automatic do_rd(input string tag, input logic [23:0] exp_d, input int exp_lat);
        int n;
        rd_req = 1'b1;
        tick();
        rd_req = 1'b0;
        n = 1;
        while (!rd_valid && n < 12) begin
            tick();
            n++;
        end
        check({tag, "_lat"},  32'(n),       32'(exp_lat));
        check({tag, "_data"}, 32'(rd_data), 32'(exp_d));
        tick();
        check({tag, "_pulse"}, 32'(rd_valid), 32'd0);
    endtask

    initial begin
        int seen;
        for (int k = 0; k < 16; k++) mem[k] = 24'h0;
        rst_n    = 1'b0;
        rec_req  = 1'b0;
        rec_data = 24'h0;
        rd_req   = 1'b0;
        clr_req  = 1'b0;
        tick();
        tick();
        check_reset_outputs("rst");
        rst_n = 1'b1;
        tick();

        // First record lands at address 0
        rec_req  = 1'b1;
        rec_data = 24'h000123;
        tick();
        rec_req = 1'b0;
        check("w1_wren",  32'(ram_wren),  32'd1);
        check("w1_addr",  32'(ram_addr),  32'd0);
        check("w1_wdata", 32'(ram_wdata), 32'h000123);
        check("w1_busy",  32'(busy),      32'd1);
        tick();
        check("w1_wren_off", 32'(ram_wren),  32'd0);
        check("w1_ack",      32'(rec_ack),   32'd1);
        check("w1_cnt",      32'(lap_count), 32'd1);
        check("w1_empty",    32'(empty),     32'd0);
        tick();
        check("w1_ack_off", 32'(rec_ack), 32'd0);

        // Fill the store with 16 laps, then overflow
        do_clr();
        check("clr_cnt", 32'(lap_count), 32'd0);
        for (int i = 1; i <= 16; i++) begin
            rec_req  = 1'b1;
            rec_data = 24'(i);
            tick();
            rec_req = 1'b0;
            check("fill_addr", 32'(ram_addr), 32'(i - 1));
            tick();
        end
        check("fill_full", 32'(full),      32'd1);
        check("fill_cnt",  32'(lap_count), 32'd16);
        rec_req  = 1'b1;
        rec_data = 24'h000011;
        tick();
        rec_req = 1'b0;
        check("ovf_drop", 32'(rec_drop),  32'd1);
        check("ovf_wren", 32'(ram_wren),  32'd0);
        check("ovf_busy", 32'(busy),      32'd0);
        check("ovf_cnt",  32'(lap_count), 32'd16);
        tick();
        check("ovf_drop_off", 32'(rec_drop), 32'd0);
        check("ovf_wren2",    32'(ram_wren), 32'd0);

        // Recall order newest to oldest with wrap: C, B, A, C
        do_clr();
        do_rec(24'h001234);
        do_rec(24'h005678);
        do_rec(24'h009012);
        tick();
        check("abc_cnt", 32'(lap_count), 32'd3);
        do_rd("rdC",  24'h009012, 3);
        do_rd("rdB",  24'h005678, 3);
        do_rd("rdA",  24'h001234, 3);
        do_rd("rdC2", 24'h009012, 3);

        // Coincident record and recall with one lap stored
        do_clr();
        do_rec(24'h000777);
        tick();
        rec_req  = 1'b1;
        rec_data = 24'h000888;
        rd_req   = 1'b1;
        tick();
        rec_req = 1'b0;
        rd_req  = 1'b0;
        check("co_wren", 32'(ram_wren), 32'd1);
        check("co_addr", 32'(ram_addr), 32'd1);
        begin
            int n;
            n = 1;
            while (!rd_valid && n < 12) begin
                tick();
                n++;
            end
            check("co_lat",  32'(n),         32'd5);
            check("co_data", 32'(rd_data),   32'h000888);
            check("co_cnt",  32'(lap_count), 32'd2);
        end
        tick();

        // Clear during RD_WAIT aborts the recall; later recall on empty store ignored
        rd_req = 1'b1;
        tick();
        rd_req = 1'b0;
        tick();
        check("ab_wait_busy", 32'(busy), 32'd1);
        clr_req = 1'b1;
        seen = 0;
        tick();
        clr_req = 1'b0;
        if (rd_valid) seen++;
        check("ab_cnt",    32'(lap_count), 32'd0);
        check("ab_empty",  32'(empty),     32'd1);
        check("ab_busy",   32'(busy),      32'd0);
        check("ab_rddata", 32'(rd_data),   32'h000888);
        rd_req = 1'b1;
        tick();
        rd_req = 1'b0;
        if (rd_valid) seen++;
        check("emp_busy", 32'(busy), 32'd0);
        for (int k = 0; k < 5; k++) begin
            tick();
            if (rd_valid) seen++;
        end
        check("ab_no_vld", 32'(seen), 32'd0);

        // Asynchronous reset in the middle of a write
        rec_req  = 1'b1;
        rec_data = 24'h000999;
        tick();
        rec_req = 1'b0;
        check("ar_wren_pre", 32'(ram_wren), 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("arst");
        tick();
        rst_n = 1'b1;
        tick();
        check("ar_post_idle", 32'(busy), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
